// File: rtl/channel_peer_pkg.sv
// Shared constants, output-stage state encoding and pointer sizing for channel_peer.
package channel_peer_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_t;

    // One extra pointer bit distinguishes full from empty.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/channel_peer_fifo.sv
// Pointer-based FIFO for channel_peer: storage, wrap-around pointers, occupancy and full/empty flags.
module channel_peer_fifo
    import channel_peer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         pop_data_c,
    output logic [ptr_w(DEPTH)-1:0]   level,
    output logic                      full_c,
    output logic                      empty_c
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            level <= level + PW'(push) - PW'(pop);
        end
    end

    // Storage needs no reset; pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign pop_data_c = mem[rd_ptr[AW-1:0]];
    assign empty_c    = (wr_ptr == rd_ptr);
    assign full_c     = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});

endmodule

// File: rtl/channel_peer.sv
// Loopback peer for the en/rdy channel: buffers rx words, adds ADD_VALUE, replays them on tx.
// Optional CHANNEL_PEER_STATS_EN builds rx/tx transfer counters; otherwise the count ports read 0.
module channel_peer
    import channel_peer_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADD_VALUE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         rx_data,
    input  logic                      rx_en,
    output logic                      rx_rdy,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_en,
    input  logic                      tx_rdy,
    output logic [ptr_w(DEPTH)-1:0]   level,
    output logic [31:0]               rx_count,
    output logic [31:0]               tx_count
);

    localparam int unsigned LW = ptr_w(DEPTH);

    out_state_t        state;
    logic              push;
    logic              pop;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic [DATA_W-1:0] head_c;
    logic [DATA_W-1:0] wdata;
    logic [LW-1:0]     level_nxt;

    assign push      = rx_en && rx_rdy && !fifo_full_c;
    assign pop       = !fifo_empty_c && ((state == ST_EMPTY) || tx_rdy);
    assign wdata     = rx_data + DATA_W'(ADD_VALUE);
    assign level_nxt = level + LW'(push) - LW'(pop);

    channel_peer_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (wdata),
        .pop        (pop),
        .pop_data_c (head_c),
        .level      (level),
        .full_c     (fifo_full_c),
        .empty_c    (fifo_empty_c)
    );

    // rx_rdy is registered from the upcoming level so it stays low through reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_rdy <= 1'b0;
        else      rx_rdy <= (level_nxt != LW'(DEPTH));
    end

    // Output slot: load from the FIFO head, hold until downstream takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_EMPTY;
            tx_en   <= 1'b0;
            tx_data <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (pop) begin
                        tx_data <= head_c;
                        tx_en   <= 1'b1;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tx_rdy) begin
                        if (pop) begin
                            tx_data <= head_c;
                        end else begin
                            tx_en <= 1'b0;
                            state <= ST_EMPTY;
                        end
                    end
                end
                default: begin
                    tx_en <= 1'b0;
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef CHANNEL_PEER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            if (push)           rx_count <= rx_count + 32'd1;
            if (tx_en && tx_rdy) tx_count <= tx_count + 32'd1;
        end
    end
`else
    assign rx_count = '0;
    assign tx_count = '0;
`endif

endmodule
